// File: rtl/tranif0_pkg.sv
// Shared types and the four-state net resolution function for the tranif0 switch.
package tranif0_pkg;

  typedef enum logic [1:0] {
    ST_Z = 2'b00,
    ST_0 = 2'b01,
    ST_1 = 2'b10,
    ST_X = 2'b11
  } logic_state_t;

  // Wired-net resolution: Z yields to the other side, agreement keeps the value,
  // and any disagreement (including X on either input) yields X.
  function automatic logic_state_t resolve(input logic_state_t x, input logic_state_t y);
    logic_state_t r;
    if (x == ST_Z)      r = y;
    else if (y == ST_Z) r = x;
    else if (x == y)    r = x;
    else                r = ST_X;
    return r;
  endfunction

endpackage

// File: rtl/tranif0_bit.sv
// Combinational resolution of one switch bit: driver states, both net states, fight flag.
module tranif0_bit
  import tranif0_pkg::*;
(
  input  logic_state_t ctrl,
  input  logic         a_en,
  input  logic         a_val,
  input  logic         b_en,
  input  logic         b_val,
  output logic_state_t a_net,
  output logic_state_t b_net,
  output logic         fight
);

  logic_state_t a_drv;
  logic_state_t b_drv;
  logic_state_t joined;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    a_drv  = ST_Z;
    b_drv  = ST_Z;
    a_net  = ST_Z;
    b_net  = ST_Z;
    if (a_en) a_drv = a_val ? ST_1 : ST_0;
    if (b_en) b_drv = b_val ? ST_1 : ST_0;
    joined = resolve(a_drv, b_drv);

    unique case (ctrl)
      ST_1: begin
        a_net = a_drv;
        b_net = b_drv;
      end
      ST_0: begin
        a_net = joined;
        b_net = joined;
      end
      default: begin
        // Unknown gate: a side keeps its own value only if conduction would not change it.
        a_net = (a_drv == joined) ? a_drv : ST_X;
        b_net = (b_drv == joined) ? b_drv : ST_X;
      end
    endcase

    fight = a_en && b_en && (a_val != b_val) && (ctrl != ST_1);
  end

endmodule

// File: rtl/tranif0_switch.sv
// Registered tranif0 switch array with sticky contention flag and saturating conduction counter.
module tranif0_switch
  import tranif0_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic_state_t         ctrl,
  input  logic [WIDTH-1:0]     a_drv_en,
  input  logic [WIDTH-1:0]     a_drv_val,
  input  logic [WIDTH-1:0]     b_drv_en,
  input  logic [WIDTH-1:0]     b_drv_val,
  input  logic                 clr_status,
  output logic [2*WIDTH-1:0]   a_state,
  output logic [2*WIDTH-1:0]   b_state,
  output logic                 contention,
  output logic [CNT_W-1:0]     conduct_cnt
);

  logic_state_t       a_net [WIDTH];
  logic_state_t       b_net [WIDTH];
  logic [WIDTH-1:0]   fight;

  logic [2*WIDTH-1:0] a_state_d, a_state_q;
  logic [2*WIDTH-1:0] b_state_d, b_state_q;
  logic               contention_d, contention_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tranif0_bit u_bit (
      .ctrl  (ctrl),
      .a_en  (a_drv_en[i]),
      .a_val (a_drv_val[i]),
      .b_en  (b_drv_en[i]),
      .b_val (b_drv_val[i]),
      .a_net (a_net[i]),
      .b_net (b_net[i]),
      .fight (fight[i])
    );
  end

  always_comb begin
    a_state_d = '0;
    b_state_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_state_d[2*i +: 2] = a_net[i];
      b_state_d[2*i +: 2] = b_net[i];
    end

    // A clear reloads from this cycle's events, so a coincident event survives it.
    if (clr_status) begin
      contention_d = |fight;
      cnt_d        = {{(CNT_W-1){1'b0}}, (ctrl == ST_0)};
    end else begin
      contention_d = contention_q | (|fight);
      cnt_d        = cnt_q;
      if ((ctrl == ST_0) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      a_state_q    <= '0;
      b_state_q    <= '0;
      contention_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      a_state_q    <= a_state_d;
      b_state_q    <= b_state_d;
      contention_q <= contention_d;
      cnt_q        <= cnt_d;
    end
  end

  assign a_state     = a_state_q;
  assign b_state     = b_state_q;
  assign contention  = contention_q;
  assign conduct_cnt = cnt_q;

endmodule

// File: tb/tb_tranif0_switch.sv
// Directed self-checking bench for tranif0_switch (WIDTH=4, CNT_W=4).
module tb_tranif0_switch;
  import tranif0_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               res;
  logic_state_t       ctrl;
  logic [WIDTH-1:0]   a_drv_en, a_drv_val, b_drv_en, b_drv_val;
  logic               clr_status;
  logic [2*WIDTH-1:0] a_state, b_state;
  logic               contention;
  logic [CNT_W-1:0]   conduct_cnt;

  int checks = 0;
  int errors = 0;

  tranif0_switch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .res         (res),
    .ctrl        (ctrl),
    .a_drv_en    (a_drv_en),
    .a_drv_val   (a_drv_val),
    .b_drv_en    (b_drv_en),
    .b_drv_val   (b_drv_val),
    .clr_status  (clr_status),
    .a_state     (a_state),
    .b_state     (b_state),
    .contention  (contention),
    .conduct_cnt (conduct_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic_state_t c, input logic [3:0] ae, input logic [3:0] av,
                       input logic [3:0] be, input logic [3:0] bv, input logic clr);
    ctrl       = c;
    a_drv_en   = ae;
    a_drv_val  = av;
    b_drv_en   = be;
    b_drv_val  = bv;
    clr_status = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic ec, input logic [3:0] en);
    check({tag, ".a"},   32'(a_state),     32'(ea));
    check({tag, ".b"},   32'(b_state),     32'(eb));
    check({tag, ".con"}, 32'(contention),  32'(ec));
    check({tag, ".cnt"}, 32'(conduct_cnt), 32'(en));
  endtask

  initial begin
    // Reset with busy inputs, checked before any clock edge.
    res = 1'b1;
    drive(ST_0, 4'hF, 4'h5, 4'hF, 4'hA, 1'b0);
    #1;
    check_all("rst_noclk", 8'h00, 8'h00, 1'b0, 4'd0);
    step();
    check_all("rst_held", 8'h00, 8'h00, 1'b0, 4'd0);
    @(negedge clk);
    res = 1'b0;

    // Open: A drives 1010, B undriven.
    drive(ST_1, 4'hF, 4'hA, 4'h0, 4'h0, 1'b0);
    step();
    check_all("open", 8'h99, 8'h00, 1'b0, 4'd0);

    // Closed pass-through: bit1=0, bit0=1 onto both sides.
    drive(ST_0, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
    step();
    check_all("closed1", 8'h06, 8'h06, 1'b0, 4'd1);
    step();
    check("closed2.cnt", 32'(conduct_cnt), 32'd2);

    // Fight on bit 0 while closed.
    drive(ST_0, 4'h1, 4'h1, 4'h1, 4'h0, 1'b0);
    step();
    check_all("fight", 8'h03, 8'h03, 1'b1, 4'd3);
    drive(ST_1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step();
    check_all("sticky", 8'h00, 8'h00, 1'b1, 4'd3);

    // Clear alone.
    drive(ST_1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    step();
    check_all("clr_alone", 8'h00, 8'h00, 1'b0, 4'd0);

    // Unknown control, A=1 B=Z on bit 0.
    drive(ST_X, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    step();
    check_all("unk_x", 8'h02, 8'h03, 1'b0, 4'd0);

    // Unknown control (Z) with a fight: both sides X and contention set.
    drive(ST_Z, 4'h1, 4'h1, 4'h1, 4'h0, 1'b0);
    step();
    check_all("unk_z_fight", 8'h03, 8'h03, 1'b1, 4'd0);

    // Clear coinciding with a closed fight: event wins, counter reloads to 1.
    drive(ST_0, 4'h4, 4'h0, 4'h4, 4'h4, 1'b1);
    step();
    check_all("clr_fight", 8'h30, 8'h30, 1'b1, 4'd1);

    // Open with opposing drivers is not contention; clear drops the flag.
    drive(ST_1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1);
    step();
    check_all("open_oppose", 8'h02, 8'h01, 1'b0, 4'd0);

    // Saturation: 20 closed cycles with nothing driven.
    drive(ST_0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 14; i++) step();
    check("cnt14", 32'(conduct_cnt), 32'd14);
    step();
    check("cnt15", 32'(conduct_cnt), 32'd15);
    for (int i = 0; i < 5; i++) step();
    check_all("sat20", 8'h00, 8'h00, 1'b0, 4'd15);

    // Mid-operation async reset, then first update after release.
    drive(ST_0, 4'h8, 4'h8, 4'h0, 4'h0, 1'b0);
    step();
    check("pre_rst.a", 32'(a_state), 32'h80);
    #2 res = 1'b1;
    #1;
    check_all("rst_mid", 8'h00, 8'h00, 1'b0, 4'd0);
    @(negedge clk);
    res = 1'b0;
    #1;
    check("post_rel.a", 32'(a_state), 32'h00);
    step();
    check_all("first_upd", 8'h80, 8'h80, 1'b0, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
